irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Interrupt front-end between peripheral interrupt sources and the CPU control unit's interrupt input.
- Synchronises raw sources and latches them as level- or edge-pending.
- Arbitrates by fixed priority and presents one request plus its source ID to the CPU.
- Sequences each interrupt through a request / acknowledge / end-of-interrupt (EOI) handshake, so only one interrupt is outstanding at a time.

Parameters:
IRQ_CH, 8, number of interrupt sources (2..32)
ID_W, 3, width of source ID; must satisfy 2**ID_W >= IRQ_CH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
irq_src  in  IRQ_CH  raw interrupt sources, may be asynchronous to clk
cfg_we  in  1  configuration write strobe, one cycle
cfg_addr  in  2  configuration register select
cfg_wdata  in  32  configuration write data
cfg_rdata  out  32  configuration read data, combinational from cfg_addr
cpu_irq  out  1  interrupt request to the CPU
cpu_irq_id  out  ID_W  ID of the requesting or in-service source
int_ack  in  1  one-cycle pulse: CPU has taken the interrupt
eoi  in  1  one-cycle pulse: handler has finished

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. All state clears immediately when reset goes low; release is synchronous to clk.
- Reset values: cpu_irq=0, cpu_irq_id=0, ENABLE=0, EDGE=0, pending=0, sync flops=0, state=IDLE.
- Configuration registers (cfg_rdata bits above IRQ_CH read 0):
  - addr 0 ENABLE: read/write, per-source enable.
  - addr 1 EDGE: read/write; 1=edge-triggered, 0=level.
  - addr 2 PENDING: reads the pending vector; writing 1 clears the matching edge-mode pending bit; no effect on level-mode bits.
  - addr 3 STATUS: read-only; [1:0]=state (IDLE=0, ASSERT=1, SERVICE=2), [8+ID_W-1:8]=cpu_irq_id.
  - Writes take effect at the next edge.
- Synchronisation: two-flop synchroniser (s1, s2) per source, plus s2_d for edge detection.
- Pending, updated every edge:
  - Level source: pending <= s2.
  - Edge source: set on s2 & ~s2_d; cleared by int_ack while selected, or by a PENDING write-1.
  - A set and a clear in the same cycle: set wins.
- req = pending & ENABLE. Priority is fixed: lowest index wins.
- Latency: irq_src high before edge 0 -> s2 at edge 1 -> pending at edge 2 -> cpu_irq=1 after edge 3.
- FSM:
  - IDLE: cpu_irq=0. If req!=0, latch cpu_irq_id = highest-priority index and go to ASSERT.
  - ASSERT: cpu_irq=1, cpu_irq_id held stable; a higher-priority arrival does not preempt.
    - int_ack -> SERVICE, and clear the selected edge-mode pending bit.
    - req[cpu_irq_id]==0 (source withdrawn, disabled or write-1 cleared) -> IDLE; cpu_irq drops after that edge.
    - int_ack and withdrawal in the same cycle: ack wins.
  - SERVICE: cpu_irq=0, cpu_irq_id held. eoi -> IDLE. Re-arbitration starts in IDLE, so a new cpu_irq rises no earlier than 2 edges after eoi.
- Ignored events: int_ack outside ASSERT; eoi outside SERVICE.
- Level source still high at eoi: re-requests normally.
- Edge pulses while the same source is in SERVICE: latched as pending and served after eoi. Multiple pulses collapse into one.
- Reset asserted mid-handshake: returns to IDLE; cpu_irq drops immediately (asynchronously).

Test Plan:
- Level, single source: ENABLE=0x04, EDGE=0; irq_src[2] high before edge 0 -> cpu_irq=1, cpu_irq_id=2 after edge 3; int_ack -> cpu_irq=0, STATUS state=2; eoi with irq_src[2] still high -> cpu_irq=1 again 2 edges later.
- Priority: ENABLE=0xFF; irq_src[5] and irq_src[1] rise together -> cpu_irq_id=1. After ack and eoi -> cpu_irq_id=5. irq_src[0] rising during ASSERT of 5 -> id stays 5.
- Edge latching: EDGE=0x08, ENABLE=0x08; one-cycle pulse on irq_src[3] -> PENDING=0x08, cpu_irq_id=3. int_ack -> PENDING=0x00. Second pulse during SERVICE -> PENDING=0x08, served after eoi.
- Withdrawal: level source 4 in ASSERT, write ENABLE=0 -> cpu_irq=0 after next edge, state=IDLE. Repeat with int_ack in the same cycle as the deassertion -> state=SERVICE.
- Write-1-clear race: edge source 6 pending; write PENDING=0x40 in the same cycle as a new detected edge on source 6 -> bit stays 1. Write with no new edge -> bit 0, and ASSERT returns to IDLE.
- Reset mid-SERVICE: drive reset low -> cpu_irq=0, ENABLE=0, PENDING=0, STATUS=0 immediately. Release -> stays idle with no request.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronises interrupt sources, latches them as level/edge pending and
// hands the highest-priority request to the CPU through a request/ack/EOI handshake.
//
// state   | meaning
// IDLE    | nothing outstanding; arbitrates pending & enable
// ASSERT  | cpu_irq high, id frozen; waits for int_ack or withdrawal
// SERVICE | handler running, cpu_irq low, id frozen; waits for eoi

module irq_arbiter #(
    parameter int IRQ_CH = 8,
    parameter int ID_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IRQ_CH-1:0] irq_src,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              cpu_irq,
    output logic [ID_W-1:0]   cpu_irq_id,
    input  logic              int_ack,
    input  logic              eoi
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    logic [IRQ_CH-1:0] enable;
    logic [IRQ_CH-1:0] edge_mode;
    logic [IRQ_CH-1:0] pending;
    logic [IRQ_CH-1:0] s1;
    logic [IRQ_CH-1:0] s2;
    logic [IRQ_CH-1:0] s2_d;
    logic [IRQ_CH-1:0] req;
    logic [IRQ_CH-1:0] edge_det;
    logic [IRQ_CH-1:0] pend_clr;
    logic [IRQ_CH-1:0] pending_nxt;
    logic [ID_W-1:0]   pick_id;
    logic              pend_wr;
    logic              ack_taken;
    logic              unused_wdata;

    assign req          = pending & enable;
    assign edge_det     = s2 & ~s2_d;
    assign pend_wr      = cfg_we && (cfg_addr == 2'd2);
    assign ack_taken    = (state == ASSERT) && int_ack;
    assign unused_wdata = ^cfg_wdata;

    // Scan from the top so the lowest requesting index is the one left standing.
    always_comb begin
        pick_id = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (req[i]) pick_id = ID_W'(i);
        end
    end

    // Edge set is OR'd in after the clear mask, so a coincident set wins.
    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < IRQ_CH; i++) begin
            pend_clr[i] = (ack_taken && (cpu_irq_id == ID_W'(i))) || (pend_wr && cfg_wdata[i]);
        end
        pending_nxt = (edge_mode & (edge_det | (pending & ~pend_clr))) | (~edge_mode & s2);
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0: cfg_rdata[IRQ_CH-1:0] = enable;
            2'd1: cfg_rdata[IRQ_CH-1:0] = edge_mode;
            2'd2: cfg_rdata[IRQ_CH-1:0] = pending;
            default: begin
                cfg_rdata[1:0]      = state;
                cfg_rdata[8 +: ID_W] = cpu_irq_id;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            s2_d      <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
        end else begin
            s1      <= irq_src;
            s2      <= s1;
            s2_d    <= s2;
            pending <= pending_nxt;
            if (cfg_we && (cfg_addr == 2'd0)) enable    <= cfg_wdata[IRQ_CH-1:0];
            if (cfg_we && (cfg_addr == 2'd1)) edge_mode <= cfg_wdata[IRQ_CH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_irq    <= 1'b0;
            cpu_irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_irq <= 1'b0;
                    if (req != '0) begin
                        cpu_irq_id <= pick_id;
                        cpu_irq    <= 1'b1;
                        state      <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (int_ack) begin
                        cpu_irq <= 1'b0;
                        state   <= SERVICE;
                    end else if (!req[cpu_irq_id]) begin
                        cpu_irq <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SERVICE: begin
                    cpu_irq <= 1'b0;
                    if (eoi) state <= IDLE;
                end
                default: begin
                    cpu_irq <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: table of single-shot arbitration vectors plus handshake sequences.

module tb_irq_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_src;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cpu_irq;
    logic [2:0]  cpu_irq_id;
    logic        int_ack;
    logic        eoi;

    irq_arbiter #(.IRQ_CH(8), .ID_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cpu_irq    (cpu_irq),
        .cpu_irq_id (cpu_irq_id),
        .int_ack    (int_ack),
        .eoi        (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [7:0] en;
        logic [7:0] edg;
        logic [7:0] src;
        logic       exp_irq;
        logic [2:0] exp_id;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_val(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_val(input logic [31:0] act);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", e.name, act, e.val);
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [31:0] mask);
        logic [31:0] d;
        rd(a, d);
        check_val(d & mask);
    endtask

    task automatic chk_irq();
        check_val({31'd0, cpu_irq});
    endtask

    task automatic chk_id();
        check_val({29'd0, cpu_irq_id});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic do_reset();
        irq_src   = '0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = '0;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;

        vecs[0] = '{en: 8'h04, edg: 8'h00, src: 8'h04, exp_irq: 1'b1, exp_id: 3'd2};
        vecs[1] = '{en: 8'hFF, edg: 8'h00, src: 8'h22, exp_irq: 1'b1, exp_id: 3'd1};
        vecs[2] = '{en: 8'hFE, edg: 8'h00, src: 8'h03, exp_irq: 1'b1, exp_id: 3'd1};
        vecs[3] = '{en: 8'h00, edg: 8'h00, src: 8'hFF, exp_irq: 1'b0, exp_id: 3'd0};
        vecs[4] = '{en: 8'h80, edg: 8'h00, src: 8'h80, exp_irq: 1'b1, exp_id: 3'd7};
        vecs[5] = '{en: 8'hF0, edg: 8'h00, src: 8'h0F, exp_irq: 1'b0, exp_id: 3'd0};
        vecs[6] = '{en: 8'hFF, edg: 8'h00, src: 8'hFF, exp_irq: 1'b1, exp_id: 3'd0};
        vecs[7] = '{en: 8'h0C, edg: 8'h0C, src: 8'h0C, exp_irq: 1'b1, exp_id: 3'd2};

        // reset values
        do_reset();
        expect_val("rst_irq", 32'd0);       chk_irq();
        expect_val("rst_id", 32'd0);        chk_id();
        expect_val("rst_enable", 32'd0);    chk_reg(2'd0, 32'hFFFF_FFFF);
        expect_val("rst_edge", 32'd0);      chk_reg(2'd1, 32'hFFFF_FFFF);
        expect_val("rst_pending", 32'd0);   chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("rst_status", 32'd0);    chk_reg(2'd3, 32'hFFFF_FFFF);

        // table: one arbitration per vector, latency boundary at edge 2 vs edge 3
        for (int v = 0; v < 8; v++) begin
            do_reset();
            wr(2'd0, {24'd0, vecs[v].en});
            wr(2'd1, {24'd0, vecs[v].edg});
            irq_src = vecs[v].src;
            tick(); tick(); tick();
            expect_val($sformatf("vec%0d_irq_edge2", v), 32'd0);
            chk_irq();
            tick();
            expect_val($sformatf("vec%0d_irq", v), {31'd0, vecs[v].exp_irq});
            chk_irq();
            expect_val($sformatf("vec%0d_status", v),
                       vecs[v].exp_irq ? {21'd0, vecs[v].exp_id, 6'd0, 2'd1} : 32'd0);
            chk_reg(2'd3, 32'hFFFF_FFFF);
            if (vecs[v].exp_irq) begin
                expect_val($sformatf("vec%0d_id", v), {29'd0, vecs[v].exp_id});
                chk_id();
            end
        end

        // level single source: request, ack, eoi with source still high
        do_reset();
        wr(2'd0, 32'h04);
        irq_src = 8'h04;
        tick(); tick(); tick();
        expect_val("lvl_irq_edge2", 32'd0); chk_irq();
        tick();
        expect_val("lvl_irq", 32'd1);       chk_irq();
        expect_val("lvl_id", 32'd2);        chk_id();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        expect_val("lvl_ack_irq", 32'd0);   chk_irq();
        expect_val("lvl_ack_status", 32'h202); chk_reg(2'd3, 32'hFFFF_FFFF);
        eoi = 1'b1; tick(); eoi = 1'b0;
        expect_val("lvl_eoi_irq", 32'd0);   chk_irq();
        expect_val("lvl_eoi_state", 32'd0); chk_reg(2'd3, 32'h3);
        tick();
        expect_val("lvl_rereq_irq", 32'd1); chk_irq();
        expect_val("lvl_rereq_id", 32'd2);  chk_id();

        // priority, no preemption, eoi ignored in ASSERT
        do_reset();
        wr(2'd0, 32'hFF);
        irq_src = 8'h22;
        tick(); tick(); tick(); tick();
        expect_val("pri_id1", 32'd1);       chk_id();
        int_ack = 1'b1; irq_src = 8'h20; tick(); int_ack = 1'b0;
        tick(); tick();
        expect_val("pri_pending", 32'h20);  chk_reg(2'd2, 32'hFFFF_FFFF);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        expect_val("pri_irq5", 32'd1);      chk_irq();
        expect_val("pri_id5", 32'd5);       chk_id();
        irq_src = 8'h21;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick(); tick(); tick();
        expect_val("pri_nopreempt_status", 32'h501); chk_reg(2'd3, 32'hFFFF_FFFF);
        expect_val("pri_nopreempt_irq", 32'd1);      chk_irq();

        // edge latching, ack clears, pulse during SERVICE served after eoi
        do_reset();
        wr(2'd1, 32'h08);
        wr(2'd0, 32'h08);
        irq_src = 8'h08; tick(); irq_src = 8'h00;
        tick(); tick();
        expect_val("edg_pending", 32'h08);  chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("edg_irq_early", 32'd0); chk_irq();
        tick();
        expect_val("edg_status", 32'h301);  chk_reg(2'd3, 32'hFFFF_FFFF);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        expect_val("edg_ack_pending", 32'h00); chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("edg_ack_status", 32'h302); chk_reg(2'd3, 32'hFFFF_FFFF);
        irq_src = 8'h08; tick(); irq_src = 8'h00;
        tick(); tick();
        expect_val("edg_svc_pending", 32'h08); chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("edg_svc_status", 32'h302); chk_reg(2'd3, 32'hFFFF_FFFF);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        expect_val("edg_reserve_irq", 32'd1); chk_irq();
        expect_val("edg_reserve_id", 32'd3);  chk_id();

        // withdrawal by disable, then ack racing the withdrawal
        do_reset();
        wr(2'd0, 32'h10);
        irq_src = 8'h10;
        tick(); tick(); tick(); tick();
        expect_val("wd_id", 32'd4);         chk_id();
        wr(2'd0, 32'h00);
        tick();
        expect_val("wd_irq", 32'd0);        chk_irq();
        expect_val("wd_state", 32'd0);      chk_reg(2'd3, 32'h3);
        wr(2'd0, 32'h10);
        tick();
        expect_val("wd2_irq", 32'd1);       chk_irq();
        wr(2'd0, 32'h00);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        expect_val("wd2_state", 32'd2);     chk_reg(2'd3, 32'h3);
        expect_val("wd2_irq_low", 32'd0);   chk_irq();
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick(); tick();
        expect_val("wd2_idle_irq", 32'd0);  chk_irq();
        expect_val("wd2_idle_state", 32'd0); chk_reg(2'd3, 32'h3);

        // write-1-clear racing a new edge, then a clean clear
        do_reset();
        wr(2'd0, 32'h40);
        wr(2'd1, 32'h40);
        irq_src = 8'h40; tick(); irq_src = 8'h00;
        tick(); tick(); tick();
        expect_val("w1c_id", 32'd6);        chk_id();
        irq_src = 8'h40; tick(); irq_src = 8'h00;
        tick();
        wr(2'd2, 32'h40);
        expect_val("w1c_race_pending", 32'h40); chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("w1c_race_state", 32'd1);    chk_reg(2'd3, 32'h3);
        wr(2'd2, 32'h40);
        expect_val("w1c_clear_pending", 32'h00); chk_reg(2'd2, 32'hFFFF_FFFF);
        tick();
        expect_val("w1c_idle_state", 32'd0); chk_reg(2'd3, 32'h3);
        expect_val("w1c_idle_irq", 32'd0);   chk_irq();

        // reset asserted mid-SERVICE
        do_reset();
        wr(2'd0, 32'h04);
        irq_src = 8'h04;
        tick(); tick(); tick(); tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        expect_val("mrst_pre_state", 32'd2); chk_reg(2'd3, 32'h3);
        reset = 1'b0;
        #1;
        expect_val("mrst_irq", 32'd0);      chk_irq();
        expect_val("mrst_enable", 32'd0);   chk_reg(2'd0, 32'hFFFF_FFFF);
        expect_val("mrst_pending", 32'd0);  chk_reg(2'd2, 32'hFFFF_FFFF);
        expect_val("mrst_status", 32'd0);   chk_reg(2'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;
        tick(); tick(); tick(); tick();
        expect_val("mrst_after_irq", 32'd0);    chk_irq();
        expect_val("mrst_after_status", 32'd0); chk_reg(2'd3, 32'hFFFF_FFFF);

        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_leftover: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
